wb_ram_slave: RTL



---
 rtl/wb_ram_slave.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_ram_slave.sv
// rtl/wb_ram_slave.sv - pipelined Wishbone B4 slave over a word-addressed SRAM
//
// Accepts one request per clock into an in-order queue and terminates each one
// exactly LAT cycles after acceptance (later if an earlier request is still
// waiting). Writes commit to the array at their response edge, so a read queued
// behind a write to the same word observes the merged data.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   wb_cyc_i         bus cycle active; low flushes all outstanding requests
//   wb_stb_i         request strobe (ignored while wb_cyc_i is low)
//   wb_we_i          1 = write, 0 = read
//   wb_adr_i         byte address; bits [1:0] ignored
//   wb_dat_i         write data
//   wb_sel_i         byte enables for writes
//   wb_dat_o         read data, registered, valid with wb_ack_o
//   wb_ack_o         normal termination pulse, one per in-window request
//   wb_err_o         error termination pulse, one per out-of-window request
//   wb_rty_o         constant 0
//   wb_stall_o       queue full; request on this cycle is not accepted

module wb_ram_slave #(
    parameter int               ADDR_W    = 32,
    parameter int               DATA_W    = 32,
    parameter int               MEM_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int               LAT       = 2,
    parameter int               Q_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [ADDR_W-1:0]   wb_adr_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
    output logic                wb_stall_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(Q_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = 4;
    localparam logic [AGE_W-1:0] LAT_A = AGE_W'(LAT);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(Q_DEPTH);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    // Queue payload and per-entry age (cycles since acceptance, saturating at LAT)
    logic              q_we_q  [Q_DEPTH];
    logic              q_we_d  [Q_DEPTH];
    logic              q_inr_q [Q_DEPTH];
    logic              q_inr_d [Q_DEPTH];
    logic [MEM_AW-1:0] q_idx_q [Q_DEPTH];
    logic [MEM_AW-1:0] q_idx_d [Q_DEPTH];
    logic [DATA_W-1:0] q_dat_q [Q_DEPTH];
    logic [DATA_W-1:0] q_dat_d [Q_DEPTH];
    logic [SEL_W-1:0]  q_sel_q [Q_DEPTH];
    logic [SEL_W-1:0]  q_sel_d [Q_DEPTH];
    logic [AGE_W-1:0]  q_age_q [Q_DEPTH];
    logic [AGE_W-1:0]  q_age_d [Q_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dat_q, dat_d;

    logic              accept;
    logic              pop;
    logic              mem_we;
    logic [DATA_W-1:0] rd_word;
    logic              unused_adr_lsb;

    assign unused_adr_lsb = ^wb_adr_i[1:0];

    // Stall depends only on the registered count: a pop this cycle does not
    // free a slot until the next cycle.
    assign wb_stall_o = (count_q == FULL);
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign wb_dat_o   = dat_q;
    assign wb_rty_o   = 1'b0;

    assign rd_word = mem[q_idx_q[rd_ptr_q]];

    always_comb begin
        q_we_d   = q_we_q;
        q_inr_d  = q_inr_q;
        q_idx_d  = q_idx_q;
        q_dat_d  = q_dat_q;
        q_sel_d  = q_sel_q;
        q_age_d  = q_age_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;

        accept = wb_cyc_i & wb_stb_i & ~wb_stall_o;
        pop    = wb_cyc_i & (count_q != '0) & (q_age_q[rd_ptr_q] >= LAT_A);
        mem_we = pop & q_we_q[rd_ptr_q] & q_inr_q[rd_ptr_q];

        for (int i = 0; i < Q_DEPTH; i++) begin
            if (q_age_q[i] < LAT_A) begin
                q_age_d[i] = q_age_q[i] + 1'b1;
            end
        end

        if (accept) begin
            q_we_d[wr_ptr_q]  = wb_we_i;
            q_inr_d[wr_ptr_q] = (wb_adr_i[ADDR_W-1:MEM_AW+2] == BASE_ADDR[ADDR_W-1:MEM_AW+2]);
            q_idx_d[wr_ptr_q] = wb_adr_i[MEM_AW+1:2];
            q_dat_d[wr_ptr_q] = wb_dat_i;
            q_sel_d[wr_ptr_q] = wb_sel_i;
            // Age 1 after the accepting edge, so the head pops LAT edges later
            q_age_d[wr_ptr_q] = AGE_W'(1);
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            if (!q_inr_q[rd_ptr_q]) begin
                err_d = 1'b1;
                dat_d = '0;
            end else begin
                ack_d = 1'b1;
                if (!q_we_q[rd_ptr_q]) begin
                    dat_d = rd_word;
                end
            end
        end

        count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

        // Dropping cyc abandons everything outstanding, queued writes included
        if (!wb_cyc_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ack_d    = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_we_q   <= '{default: '0};
            q_inr_q  <= '{default: '0};
            q_idx_q  <= '{default: '0};
            q_dat_q  <= '{default: '0};
            q_sel_q  <= '{default: '0};
            q_age_q  <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            q_we_q   <= q_we_d;
            q_inr_q  <= q_inr_d;
            q_idx_q  <= q_idx_d;
            q_dat_q  <= q_dat_d;
            q_sel_q  <= q_sel_d;
            q_age_q  <= q_age_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
        end
    end

    // Array contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < SEL_W; b++) begin
                if (q_sel_q[rd_ptr_q][b]) begin
                    mem[q_idx_q[rd_ptr_q]][b*8 +: 8] <= q_dat_q[rd_ptr_q][b*8 +: 8];
                end
            end
        end
    end

endmodule
